// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue                                                                |
// | Decoupled instruction fetch: sequential PC generator, credit-limited imem  |
// | request/response port, QDEPTH-entry instruction queue toward decode.       |
// | Optional feature macro: FETCH_PERF_EN (performance counters).              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h80000000,
  parameter int                QDEPTH       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects
);

  localparam int              c_PTR_W   = $clog2(QDEPTH);
  localparam logic [c_PTR_W+1:0] c_DEPTH = (c_PTR_W+2)'(QDEPTH);
  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] c_ALIGN   = ~XLEN'(3);

  logic [XLEN-1:0]    r_req_pc;
  logic [XLEN-1:0]    r_resp_pc;
  logic [c_PTR_W:0]   r_count;
  logic [c_PTR_W:0]   r_inflight;
  logic [c_PTR_W:0]   r_drop_cnt;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [XLEN-1:0]    r_q_data [QDEPTH];
  logic [XLEN-1:0]    r_q_pc   [QDEPTH];

  logic [c_PTR_W+1:0] w_used;
  logic               w_req_fire;
  logic               w_push;
  logic               w_pop;
  logic               w_dropping;
  logic [XLEN-1:0]    w_redirect_pc;
  logic [c_PTR_W:0]   w_fire_inc;
  logic [c_PTR_W:0]   w_resp_dec;

  // Credits cover both queued and in-flight entries, so the queue can never overflow.
  assign w_used         = {1'b0, r_count} + {1'b0, r_inflight};
  assign imem_req_valid = ~rst & ~redirect_valid & (w_used < c_DEPTH);
  assign imem_req_addr  = r_req_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign inst_valid = ~rst & ~redirect_valid & (r_count != '0);
  assign inst_data  = r_q_data[r_rd_ptr];
  assign inst_pc    = r_q_pc[r_rd_ptr];
  assign w_pop      = inst_valid & inst_ready;

  assign w_dropping    = (r_drop_cnt != '0);
  assign w_push        = imem_resp_valid & ~w_dropping & ~redirect_valid;
  assign w_redirect_pc = redirect_pc & c_ALIGN;
  assign w_fire_inc    = {{c_PTR_W{1'b0}}, w_req_fire};
  assign w_resp_dec    = {{c_PTR_W{1'b0}}, imem_resp_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pc   <= RESET_VECTOR;
      r_resp_pc  <= RESET_VECTOR;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight becomes stale; a response landing now is one of them.
      r_req_pc   <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= r_inflight - w_resp_dec;
      r_drop_cnt <= r_inflight - w_resp_dec;
    end else begin
      if (w_req_fire) begin
        r_req_pc <= r_req_pc + c_PC_STEP;
      end
      r_inflight <= r_inflight + w_fire_inc - w_resp_dec;
      if (imem_resp_valid && w_dropping) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + c_PC_STEP;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= imem_resp_data;
      r_q_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_redirects = r_perf_redirects;
`else
  assign perf_fetched   = 32'd0;
  assign perf_redirects = 32'd0;
`endif

endmodule
`default_nettype wire
